// File: rtl/mem_stage_lsu_if.sv
// rtl/mem_stage_lsu_if.sv - execute, data-memory and writeback signals of the memory stage
interface mem_stage_lsu_if;
    logic        flush;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        stall_o;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [31:0] wb_data;
    logic        exc_misaligned;
    logic        exc_fault;

    modport master (
        input  flush, ex_valid, ex_pc, ex_alu_result, ex_store_data, ex_mem_read,
               ex_mem_write, ex_funct3, ex_rd, ex_reg_write, dmem_ack, dmem_rdata,
        output stall_o, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
               wb_valid, wb_pc, wb_rd, wb_reg_write, wb_data, exc_misaligned, exc_fault
    );

    modport slave (
        output flush, ex_valid, ex_pc, ex_alu_result, ex_store_data, ex_mem_read,
               ex_mem_write, ex_funct3, ex_rd, ex_reg_write, dmem_ack, dmem_rdata,
        input  stall_o, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
               wb_valid, wb_pc, wb_rd, wb_reg_write, wb_data, exc_misaligned, exc_fault
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - load/store unit of the memory stage with access timeout
module mem_stage_lsu #(
    parameter int TIMEOUT = 16
) (
    input logic           clk,
    input logic           rst,
    mem_stage_lsu_if.master bus
);
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    ld_funct3;
    logic [1:0]    ld_off;
    logic          pend_reg_write;

    logic       accept, mem_op, bad_op, misaligned;
    logic [1:0] off;
    logic [3:0] st_be;
    logic [31:0] st_wdata, ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign accept = bus.ex_valid && (state == IDLE) && !bus.flush;
    assign mem_op = bus.ex_mem_read || bus.ex_mem_write;
    assign off    = bus.ex_alu_result[1:0];
    assign bad_op = (bus.ex_mem_read && bus.ex_mem_write) || (bus.ex_funct3 == 3'b011)
                 || (bus.ex_funct3 == 3'b110) || (bus.ex_funct3 == 3'b111);
    assign misaligned = ((bus.ex_funct3[1:0] == 2'b01) && off[0])
                     || ((bus.ex_funct3[1:0] == 2'b10) && (off != 2'b00));

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = bus.ex_store_data;
        case (bus.ex_funct3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << off;
                st_wdata = {4{bus.ex_store_data[7:0]}};
            end
            2'b01: begin
                st_be    = off[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{bus.ex_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lane selection uses the offset captured at acceptance, not the live bus.
    always_comb begin
        ld_half = ld_off[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
        case (ld_off)
            2'b00:   ld_byte = bus.dmem_rdata[7:0];
            2'b01:   ld_byte = bus.dmem_rdata[15:8];
            2'b10:   ld_byte = bus.dmem_rdata[23:16];
            default: ld_byte = bus.dmem_rdata[31:24];
        endcase
        case (ld_funct3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = bus.dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            cnt                <= '0;
            ld_funct3          <= '0;
            ld_off             <= '0;
            pend_reg_write     <= 1'b0;
            bus.stall_o        <= 1'b0;
            bus.dmem_req       <= 1'b0;
            bus.dmem_we        <= 1'b0;
            bus.dmem_addr      <= '0;
            bus.dmem_be        <= '0;
            bus.dmem_wdata     <= '0;
            bus.wb_valid       <= 1'b0;
            bus.wb_pc          <= '0;
            bus.wb_rd          <= '0;
            bus.wb_reg_write   <= 1'b0;
            bus.wb_data        <= '0;
            bus.exc_misaligned <= 1'b0;
            bus.exc_fault      <= 1'b0;
        end else begin
            bus.wb_valid       <= 1'b0;
            bus.exc_misaligned <= 1'b0;
            bus.exc_fault      <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    bus.wb_pc   <= bus.ex_pc;
                    bus.wb_rd   <= bus.ex_rd;
                    bus.wb_data <= bus.ex_alu_result;
                    if (!mem_op) begin
                        bus.wb_valid     <= 1'b1;
                        bus.wb_reg_write <= bus.ex_reg_write;
                    end else if (bad_op || misaligned) begin
                        bus.wb_valid       <= 1'b1;
                        bus.wb_reg_write   <= 1'b0;
                        bus.exc_fault      <= bad_op;
                        bus.exc_misaligned <= !bad_op;
                    end else begin
                        state          <= BUSY;
                        bus.stall_o    <= 1'b1;
                        bus.dmem_req   <= 1'b1;
                        bus.dmem_we    <= bus.ex_mem_write;
                        bus.dmem_addr  <= {bus.ex_alu_result[31:2], 2'b00};
                        bus.dmem_be    <= bus.ex_mem_write ? st_be : 4'b1111;
                        bus.dmem_wdata <= bus.ex_mem_write ? st_wdata : 32'd0;
                        cnt            <= '0;
                        ld_funct3      <= bus.ex_funct3;
                        ld_off         <= off;
                        pend_reg_write <= bus.ex_mem_read && bus.ex_reg_write;
                    end
                end
                BUSY: begin
                    // An ack in the final counted cycle still completes the access.
                    if (bus.dmem_ack) begin
                        state            <= IDLE;
                        bus.stall_o      <= 1'b0;
                        bus.dmem_req     <= 1'b0;
                        bus.wb_valid     <= 1'b1;
                        bus.wb_reg_write <= pend_reg_write;
                        bus.wb_data      <= ld_data;
                    end else if (cnt == CNT_LAST) begin
                        state            <= IDLE;
                        bus.stall_o      <= 1'b0;
                        bus.dmem_req     <= 1'b0;
                        bus.wb_valid     <= 1'b1;
                        bus.wb_reg_write <= 1'b0;
                        bus.exc_fault    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - randomized self-checking bench for mem_stage_lsu
module tb_mem_stage_lsu;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_stage_lsu_if bif ();
    mem_stage_lsu #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bif));

    int checks = 0;
    int failures = 0;
    logic [31:0] pc_ctr = 32'h1000;

    task automatic drive_op(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] sdata, input bit regw, input logic [4:0] rdn);
        bif.ex_valid = 1'b1;      bif.ex_pc = pc_ctr;       bif.ex_alu_result = addr;
        bif.ex_store_data = sdata; bif.ex_mem_read = rd;    bif.ex_mem_write = wr;
        bif.ex_funct3 = f3;       bif.ex_rd = rdn;          bif.ex_reg_write = regw;
    endtask

    task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sdata, input int ack_cyc, input logic [31:0] rdata, input bit regw);
        int size, off;
        bit memop, fault, mis, acked;
        logic [3:0] exp_be;
        logic [31:0] exp_wd, mask, v;
        logic [4:0] rdn;
        rdn = 5'($urandom);
        pc_ctr = pc_ctr + 4;
        memop = rd || wr;
        fault = memop && ((rd && wr) || f3 == 3 || f3 >= 6);
        size = 1 << f3[1:0];
        off = int'(addr % 4);
        mis = memop && !fault && (addr % size != 0);
        @(negedge clk);
        drive_op(rd, wr, f3, addr, sdata, regw, rdn);
        @(negedge clk);
        bif.ex_valid = 1'b0;
        bif.ex_alu_result = $urandom;
        if (!memop || fault || mis) begin
            checks++;
            if ({bif.wb_valid, bif.dmem_req, bif.stall_o, bif.exc_fault, bif.exc_misaligned} !== {1'b1, 1'b0, 1'b0, fault, mis}) begin
                failures++;
                $display("FAIL imm_retire flags got=%b exp=%b", {bif.wb_valid, bif.dmem_req, bif.stall_o, bif.exc_fault, bif.exc_misaligned}, {1'b1, 1'b0, 1'b0, fault, mis});
            end
            checks++;
            if ({bif.wb_pc, bif.wb_rd, bif.wb_reg_write} !== {pc_ctr, rdn, regw && !memop}) begin
                failures++;
                $display("FAIL imm_fields got=%h/%0d/%b exp=%h/%0d/%b", bif.wb_pc, bif.wb_rd, bif.wb_reg_write, pc_ctr, rdn, regw && !memop);
            end
            if (!memop) begin
                checks++;
                if (bif.wb_data !== addr) begin
                    failures++;
                    $display("FAIL alu_data got=%h exp=%h", bif.wb_data, addr);
                end
            end
        end else begin
            exp_be = wr ? 4'(((1 << size) - 1) << off) : 4'hF;
            exp_wd = (size == 1) ? sdata[7:0] * 32'h01010101 : (size == 2) ? sdata[15:0] * 32'h00010001 : sdata;
            acked = 1'b0;
            for (int c = 1; c <= TO; c++) begin
                checks++;
                if ({bif.dmem_req, bif.stall_o, bif.wb_valid, bif.dmem_we, bif.dmem_be} !== {1'b1, 1'b1, 1'b0, wr, exp_be}
                    || bif.dmem_addr !== (addr & ~32'd3) || (wr && bif.dmem_wdata !== exp_wd)) begin
                    failures++;
                    $display("FAIL busy_bus c=%0d got req/stall/wbv/we/be=%b addr=%h wd=%h exp be=%b addr=%h wd=%h", c,
                             {bif.dmem_req, bif.stall_o, bif.wb_valid, bif.dmem_we, bif.dmem_be}, bif.dmem_addr, bif.dmem_wdata,
                             exp_be, addr & ~32'd3, exp_wd);
                end
                bif.flush = 1'($urandom);
                bif.ex_valid = 1'($urandom);
                if (c == ack_cyc) begin
                    bif.dmem_ack = 1'b1;
                    bif.dmem_rdata = rdata;
                end
                @(negedge clk);
                bif.dmem_ack = 1'b0; bif.dmem_rdata = $urandom; bif.ex_valid = 1'b0; bif.flush = 1'b0;
                if (c == ack_cyc) begin
                    acked = 1'b1;
                    break;
                end
            end
            checks++;
            if ({bif.wb_valid, bif.dmem_req, bif.stall_o, bif.exc_fault, bif.exc_misaligned, bif.wb_reg_write} !==
                {1'b1, 1'b0, 1'b0, !acked, 1'b0, acked && rd && regw}) begin
                failures++;
                $display("FAIL mem_retire got=%b exp=%b", {bif.wb_valid, bif.dmem_req, bif.stall_o, bif.exc_fault, bif.exc_misaligned, bif.wb_reg_write},
                         {1'b1, 1'b0, 1'b0, !acked, 1'b0, acked && rd && regw});
            end
            if (acked && rd) begin
                mask = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 1;
                v = (rdata >> (8 * off)) & mask;
                if (f3 < 4 && size < 4 && v[8 * size - 1]) v = v | ~mask;
                checks++;
                if (bif.wb_data !== v) begin
                    failures++;
                    $display("FAIL load_data f3=%0d addr=%h got=%h exp=%h", f3, addr, bif.wb_data, v);
                end
            end
        end
        @(negedge clk);
        checks++;
        if ({bif.wb_valid, bif.exc_fault, bif.exc_misaligned, bif.stall_o} !== 4'b0000) begin
            failures++;
            $display("FAIL quiet_after got=%b exp=0000", {bif.wb_valid, bif.exc_fault, bif.exc_misaligned, bif.stall_o});
        end
    endtask

    task automatic test_reset();
        bif.ex_valid = 0; bif.flush = 0; bif.dmem_ack = 0; bif.dmem_rdata = 0;
        bif.ex_mem_read = 0; bif.ex_mem_write = 0; bif.ex_funct3 = 0; bif.ex_pc = 0;
        bif.ex_alu_result = 0; bif.ex_store_data = 0; bif.ex_rd = 0; bif.ex_reg_write = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bif.stall_o, bif.dmem_req, bif.wb_valid, bif.exc_fault, bif.exc_misaligned, bif.wb_reg_write} !== 6'b0
            || bif.wb_data !== 32'd0 || bif.wb_pc !== 32'd0 || bif.dmem_addr !== 32'd0) begin
            failures++;
            $display("FAIL reset_state got=%b data=%h pc=%h addr=%h exp all zero", {bif.stall_o, bif.dmem_req, bif.wb_valid,
                     bif.exc_fault, bif.exc_misaligned, bif.wb_reg_write}, bif.wb_data, bif.wb_pc, bif.dmem_addr);
        end
        pc_ctr = pc_ctr + 4;
        drive_op(1'b0, 1'b0, 3'b000, 32'h0000_ABCD, 32'd0, 1'b1, 5'd7);
        rst = 1'b0;
        @(negedge clk);
        bif.ex_valid = 1'b0;
        checks++;
        if (bif.wb_valid !== 1'b1 || bif.wb_data !== 32'h0000_ABCD) begin
            failures++;
            $display("FAIL first_accept got wbv=%b data=%h exp 1/0000abcd", bif.wb_valid, bif.wb_data);
        end
    endtask

    task automatic test_directed();
        run_op(1, 0, 3'b010, 32'h100, 32'd0, 4, 32'hDEADBEEF, 1);
        run_op(1, 0, 3'b000, 32'h103, 32'd0, 1, 32'h80FF_0000, 1);
        run_op(1, 0, 3'b100, 32'h103, 32'd0, 2, 32'h80FF_0000, 1);
        run_op(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 2, 32'd0, 1);
        run_op(0, 1, 3'b000, 32'h201, 32'h55, 1, 32'd0, 0);
        run_op(1, 0, 3'b010, 32'h102, 32'd0, 1, 32'd0, 1);
        run_op(1, 0, 3'b001, 32'h101, 32'd0, 1, 32'd0, 1);
        run_op(1, 0, 3'b010, 32'h300, 32'd0, 0, 32'd0, 1);
        run_op(1, 0, 3'b010, 32'h304, 32'd0, TO, 32'hCAFE_F00D, 1);
        run_op(1, 0, 3'b011, 32'h308, 32'd0, 1, 32'd0, 1);
        run_op(1, 1, 3'b010, 32'h30C, 32'd0, 1, 32'd0, 1);
    endtask

    task automatic test_random();
        logic [2:0] f3;
        bit rd, wr;
        for (int i = 0; i < 40; i++) begin
            rd = 0; wr = 0;
            case ($urandom_range(0, 9))
                0, 1:    ;
                2:       begin rd = 1; wr = ($urandom_range(0, 3) == 0); end
                3, 4, 5: wr = 1;
                default: rd = 1;
            endcase
            if (wr && !rd) f3 = 3'($urandom_range(0, 2));
            else begin
                case ($urandom_range(0, 6))
                    0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100;
                    4: f3 = 3'b101; 5: f3 = 3'b110; default: f3 = 3'b010;
                endcase
            end
            run_op(rd, wr, f3, $urandom & 32'h0000_0FFF, $urandom, $urandom_range(1, TO + 3), $urandom, 1'($urandom));
        end
    endtask

    task automatic test_reset_busy();
        @(negedge clk);
        drive_op(1'b1, 1'b0, 3'b010, 32'h400, 32'd0, 1'b1, 5'd3);
        repeat (2) @(negedge clk);
        bif.ex_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bif.dmem_req, bif.stall_o, bif.wb_valid} !== 3'b000) begin
            failures++;
            $display("FAIL async_reset got=%b exp=000", {bif.dmem_req, bif.stall_o, bif.wb_valid});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({bif.wb_valid, bif.dmem_req, bif.stall_o} !== 3'b000) begin
                failures++;
                $display("FAIL post_reset_quiet got=%b exp=000", {bif.wb_valid, bif.dmem_req, bif.stall_o});
            end
        end
    endtask

    task automatic test_flush_and_idle_ack();
        @(negedge clk);
        drive_op(1'b1, 1'b0, 3'b010, 32'h500, 32'd0, 1'b1, 5'd9);
        bif.flush = 1'b1;
        @(negedge clk);
        drive_op(1'b0, 1'b0, 3'b000, 32'h77, 32'd0, 1'b1, 5'd9);
        @(negedge clk);
        bif.ex_valid = 1'b0; bif.flush = 1'b0;
        bif.dmem_ack = 1'b1;
        @(negedge clk);
        bif.dmem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({bif.wb_valid, bif.dmem_req, bif.stall_o, bif.exc_fault} !== 4'b0000) begin
                failures++;
                $display("FAIL flush_idle_ack got=%b exp=0000", {bif.wb_valid, bif.dmem_req, bif.stall_o, bif.exc_fault});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] prev;
        prev = 32'd0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (bif.wb_valid !== 1'b1 || bif.wb_data !== prev) begin
                    failures++;
                    $display("FAIL back_to_back i=%0d got wbv=%b data=%h exp 1/%h", i, bif.wb_valid, bif.wb_data, prev);
                end
            end
            prev = $urandom;
            pc_ctr = pc_ctr + 4;
            if (i < 8) drive_op(1'b0, 1'b0, 3'b000, prev, 32'd0, 1'b1, 5'(i));
            else bif.ex_valid = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_reset_busy();
        test_flush_and_idle_ack();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout reached exp=finish before bound");
        $fatal(1);
    end
endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, which sets the number of BUSY cycles without dmem_ack before an access fault.
REQ-002 SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port flush  in  1  when high, the instruction offered from execute this cycle is discarded.
REQ-005 SHALL have port ex_valid  in  1  execute stage presents an instruction.
REQ-006 SHALL have port ex_pc  in  32  PC of the offered instruction.
REQ-007 SHALL have port ex_alu_result  in  32  byte address for memory ops, or result for other ops.
REQ-008 SHALL have port ex_store_data  in  32  store source register value.
REQ-009 SHALL have port ex_mem_read / ex_mem_write  in  1 each  load / store select.
REQ-010 SHALL have port ex_funct3  in  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-011 SHALL have port ex_rd  in  5, and port ex_reg_write  in  1; these carry the destination register and its write enable.
REQ-012 SHALL have port stall_o  out  1  upstream hold; execute keeps its outputs stable while high.
REQ-013 SHALL have port dmem_req  out  1, dmem_we  out  1, dmem_addr  out  32 (word-aligned, [1:0]=00), dmem_be  out  4, and dmem_wdata  out  32.
REQ-014 SHALL have port dmem_ack  in  1  one-cycle completion pulse, and port dmem_rdata  in  32  read word, valid with dmem_ack.
REQ-015 SHALL have port wb_valid  out  1, a one-cycle pulse per retired instruction; the writeback stage applies no backpressure.
REQ-016 SHALL have port wb_pc  out  32, wb_rd  out  5, wb_reg_write  out  1, and wb_data  out  32; these are registered writeback fields.
REQ-017 SHALL have port exc_misaligned  out  1 and port exc_fault  out  1; both are qualified by wb_valid.

Function
REQ-018 SHALL implement FSM states IDLE and BUSY, with stall_o = (state == BUSY).
REQ-019 SHALL accept an instruction when ex_valid && !stall_o && !flush, and SHALL ignore the execute inputs otherwise.
REQ-020 For an accepted non-memory op, the block SHALL pulse wb_valid the next cycle with wb_data = ex_alu_result and the captured pc/rd/reg_write fields (latency 1).
REQ-021 An accepted aligned load or store SHALL go to BUSY; dmem_req SHALL be registered high from the next cycle and held, with addr/we/be/wdata stable, until the cycle dmem_ack is sampled high.
REQ-022 Store byte enables SHALL be: SB be = 1<<addr[1:0] with wdata = byte replicated x4; SH be = 0011 or 1100 by addr[1] with wdata = half replicated x2; SW be = 1111.
REQ-023 Loads SHALL set dmem_we = 0 and be = 1111, and SHALL extract the byte or half at addr[1:0] from dmem_rdata; B and H SHALL sign-extend, and BU and HU SHALL zero-extend.
REQ-024 On dmem_ack in BUSY, the block SHALL drop dmem_req, return to IDLE, and pulse wb_valid the next cycle with the formatted load data (store: wb_reg_write = 0); the memory op latency from ack is 1.
REQ-025 Misalignment (H with addr[0] = 1; W with addr[1:0] != 0) SHALL issue no request and SHALL pulse wb_valid next cycle with exc_misaligned = 1 and wb_reg_write = 0.
REQ-026 The following SHALL be faults with no request, a wb_valid pulse next cycle, exc_fault = 1, and wb_reg_write = 0: funct3 011/110/111 on a memory op, or ex_mem_read && ex_mem_write.
REQ-027 A timeout counter SHALL clear on entry to BUSY and increment each BUSY cycle; if it reaches TIMEOUT-1 without ack, the block SHALL drop dmem_req, return to IDLE, and pulse wb_valid with exc_fault = 1 and wb_reg_write = 0.
REQ-028 An ack arriving in the same cycle the count reaches TIMEOUT-1 SHALL complete normally (ack wins).
REQ-029 flush SHALL be ignored while in BUSY; an outstanding access always completes or times out.
REQ-030 dmem_ack while in IDLE SHALL be ignored.
REQ-031 wb_valid, exc_misaligned, and exc_fault SHALL be low in every cycle without a retirement.

Reset
REQ-032 On rst, the block SHALL asynchronously set state = IDLE, counter = 0, and all outputs = 0, including dmem_req, stall_o, and wb_*; an in-flight access SHALL be abandoned with no retirement.
REQ-033 After rst deasserts, the first acceptance SHALL be possible on the first rising edge.

Verification
REQ-034 LW at 0x100, ack 3 cycles after req, rdata 0xDEADBEEF -> stall_o high 4 cycles, wb_valid 1 cycle after ack, wb_data = 0xDEADBEEF.
REQ-035 LB at 0x103 and LBU at 0x103 with rdata 0x80FF_0000 -> wb_data = 0xFFFFFF80 and 0x00000080.
REQ-036 SH at 0x202 with data 0x1234ABCD -> dmem_addr 0x200, be 1100, wdata 0xABCDABCD; then SB at 0x201 with 0x55 -> be 0010, wdata 0x55555555.
REQ-037 LW at 0x102 -> no dmem_req, wb_valid next cycle, exc_misaligned = 1, wb_reg_write = 0; LH at 0x101 -> same.
REQ-038 LW with no ack -> dmem_req held for TIMEOUT cycles, then exc_fault = 1; repeat with ack on the final cycle -> normal completion, exc_fault = 0.
REQ-039 rst pulsed 2 cycles into BUSY -> dmem_req and stall_o drop immediately, no wb_valid; flush high with ex_valid in IDLE -> no retirement.
